// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 31,250 baud UART framing plus a channel-voice parser
// with running status, emitting one command/data packet per complete message.
module midi_uart_rx #(
   parameter int BYTE_W       = 8,
   parameter int CLKS_PER_BIT = 768
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              midi_rx,
   output logic [BYTE_W-1:0] MIDI_CMD,
   output logic [BYTE_W-1:0] MIDI_DAT_0,
   output logic [BYTE_W-1:0] MIDI_DAT_1,
   output logic              MIDI_PACKET_RDY,
   output logic              rx_frame_err
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BIW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
   localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [BIW-1:0] LAST_BIT = BIW'(BYTE_W - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   logic              r_rx_meta, r_rx_s;
   state_t            r_state, w_state_nx;
   logic [CW-1:0]     r_cnt, w_cnt_nx;
   logic [BIW-1:0]    r_bit, w_bit_nx;
   logic [BYTE_W-1:0] r_shift, w_shift_nx;
   logic              r_byte_vld, w_byte_vld_nx;
   logic              r_frame_err, w_frame_err_nx;
   logic              w_tick;

   // Parser state; running status of zero means "none" since status bytes have the MSB set
   logic [BYTE_W-1:0] r_run, r_pend;
   logic              r_have;
   logic [BYTE_W-1:0] r_cmd, r_dat0, r_dat1;
   logic              r_rdy;
   logic [3:0]        w_hi, w_run_hi;
   logic              w_is_rt, w_is_sys, w_is_status, w_len1;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= midi_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_bit       <= w_bit_nx;
         r_shift     <= w_shift_nx;
         r_byte_vld  <= w_byte_vld_nx;
         r_frame_err <= w_frame_err_nx;
      end
   end

   assign w_tick = (r_cnt == '0);

   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = w_tick ? r_cnt : r_cnt - 1'b1;
      w_bit_nx       = r_bit;
      w_shift_nx     = r_shift;
      w_byte_vld_nx  = 1'b0;
      w_frame_err_nx = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_rx_s) begin
               w_cnt_nx   = HALF_M1;
               w_state_nx = S_START;
            end
         end
         S_START: begin
            if (w_tick) begin
               if (r_rx_s) begin
                  w_state_nx = S_IDLE;
               end else begin
                  w_cnt_nx   = FULL_M1;
                  w_bit_nx   = '0;
                  w_state_nx = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift_nx = {r_rx_s, r_shift[BYTE_W-1:1]};
               w_cnt_nx   = FULL_M1;
               if (r_bit == LAST_BIT) w_state_nx = S_STOP;
               else                   w_bit_nx   = r_bit + 1'b1;
            end
         end
         S_STOP: begin
            if (w_tick) begin
               if (r_rx_s) begin
                  w_byte_vld_nx = 1'b1;
                  w_state_nx    = S_IDLE;
               end else begin
                  w_frame_err_nx = 1'b1;
                  w_state_nx     = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // a held-low line must return high before a new start bit counts
            if (r_rx_s) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign w_hi        = r_shift[BYTE_W-1 -: 4];
   assign w_run_hi    = r_run[BYTE_W-1 -: 4];
   assign w_is_rt     = (w_hi == 4'hF) &&  r_shift[BYTE_W-5];
   assign w_is_sys    = (w_hi == 4'hF) && !r_shift[BYTE_W-5];
   assign w_is_status = r_shift[BYTE_W-1];
   assign w_len1      = (w_run_hi == 4'hC) || (w_run_hi == 4'hD);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_run  <= '0;
         r_pend <= '0;
         r_have <= 1'b0;
         r_cmd  <= '0;
         r_dat0 <= '0;
         r_dat1 <= '0;
         r_rdy  <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         if (r_frame_err) begin
            r_have <= 1'b0;
         end else if (r_byte_vld) begin
            if (w_is_rt) begin
               r_have <= r_have;
            end else if (w_is_sys) begin
               r_run  <= '0;
               r_have <= 1'b0;
            end else if (w_is_status) begin
               r_run  <= r_shift;
               r_have <= 1'b0;
            end else if (r_run != '0) begin
               if (!r_have) begin
                  r_pend <= r_shift;
                  if (w_len1) begin
                     r_cmd  <= r_run;
                     r_dat0 <= r_shift;
                     r_dat1 <= '0;
                     r_rdy  <= 1'b1;
                  end else begin
                     r_have <= 1'b1;
                  end
               end else begin
                  r_cmd  <= r_run;
                  r_dat0 <= r_pend;
                  r_dat1 <= r_shift;
                  r_rdy  <= 1'b1;
                  r_have <= 1'b0;
               end
            end
         end
      end
   end

   assign MIDI_CMD        = r_cmd;
   assign MIDI_DAT_0      = r_dat0;
   assign MIDI_DAT_1      = r_dat1;
   assign MIDI_PACKET_RDY = r_rdy;
   assign rx_frame_err    = r_frame_err;

endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Serial MIDI front end: receives the 31,250 baud MIDI UART stream on a single input pin. It assembles channel-voice messages into command and data byte packets, applying running status. Each complete message is presented on `MIDI_CMD` / `MIDI_DAT_0` / `MIDI_DAT_1` with a one-cycle `MIDI_PACKET_RDY` strobe. It sits between the board MIDI input and the MIDI control unit, which consumes exactly that packet interface.

## Interface
- `BYTE_W`, 8: MIDI byte width.
- `CLKS_PER_BIT`, 768: `sys_clk` cycles per UART bit (24 MHz / 31,250). Must be an even number ≥ 8.
- `sys_clk`, in, 1: the single clock. All logic is on the rising edge.
- `sys_rst`, in, 1: reset, asynchronous, active-high.
- `midi_rx`, in, 1: raw serial input. Idle high, asynchronous to `sys_clk`.
- `MIDI_CMD`, out, BYTE_W: status byte of the last completed message.
- `MIDI_DAT_0`, out, BYTE_W: first data byte.
- `MIDI_DAT_1`, out, BYTE_W: second data byte. 0x00 for one-data-byte messages.
- `MIDI_PACKET_RDY`, out, 1: one-cycle strobe. The three byte outputs are valid from this cycle and stay held until the next strobe.
- `rx_frame_err`, out, 1: one-cycle strobe on a stop-bit error.

## Operation
- Reset values:
  - All outputs are 0.
  - Running status is cleared (none).
  - Data count is 0.
  - Receiver is in IDLE.
  - Synchronizer flops are set to 1.
- `midi_rx` passes through a 2-flop synchronizer. All sampling uses the synchronized value `rx_s`.
- Receiver FSM:
  - IDLE: on `rx_s` = 0, load the bit counter and go to START.
  - START: after `CLKS_PER_BIT/2` cycles, sample `rx_s`. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. 8 bits, LSB first, shifted into a byte register. Then go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - If 1: raise the internal `byte_vld` for one cycle, then go to IDLE.
    - If 0: pulse `rx_frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s` = 1, then go to IDLE.
- Parser: acts on `byte_vld` only.
  - 0xF8–0xFF (realtime): ignored entirely. Running status, data count and held data are unchanged.
  - 0xF0–0xF7 (sysex/system common): clear running status and set count to 0. All following data bytes are dropped until the next status byte.
  - 0x80–0xEF (channel status): store as running status and set count to 0. Expected length is 2 for 0x8n, 0x9n, 0xAn, 0xBn and 0xEn, and 1 for 0xCn and 0xDn.
  - 0x00–0x7F (data), no running status: dropped.
  - Data, count 0: store as DAT_0.
    - Length 1: emit the packet with DAT_1 = 0x00 and keep count at 0.
    - Otherwise: set count to 1.
  - Data, count 1: store as DAT_1, emit the packet, set count to 0. Running status is retained, so the next data byte starts a new packet.
- Emit:
  - Register `MIDI_CMD` = running status and both data bytes together.
  - Pulse `MIDI_PACKET_RDY` high for exactly one cycle.
- Framing error: count is set to 0 and any partial message is discarded. Running status is kept.
- Bytes are passed through unmodified. Note-on with velocity 0 is not rewritten.

## Timing
- Latency:
  - The stop-bit sample occurs at cycle S.
  - `byte_vld` is high at S+1.
  - `MIDI_PACKET_RDY` and the updated outputs appear at S+2, registered.
- `rx_frame_err` is high at S+1 on a bad stop bit.
- Output timing:
  - Strobes are never high for two consecutive cycles.
  - Minimum spacing between strobes is 10 × `CLKS_PER_BIT` cycles.
  - The consumer needs no backpressure; none is provided.
- Bit sampling:
  - Sample points are the start-edge detect plus `CLKS_PER_BIT/2 + k·CLKS_PER_BIT`, for k = 0..9.
  - Sampling tolerates ±2 % baud error.
- A low pulse shorter than `CLKS_PER_BIT/2` cycles produces no byte and no error.
- `sys_rst` asserted mid-byte or mid-message:
  - All state returns to reset values immediately (asynchronously).
  - No strobe is produced.
  - After release, reception resumes at the next falling edge.
- A falling edge during STOP/BREAK is not treated as a start bit until IDLE is re-entered.

## Test plan
(Bench uses `CLKS_PER_BIT` = 16.)
- Send 0x90, 0x3C, 0x64: exactly one strobe with CMD = 0x90, DAT_0 = 0x3C, DAT_1 = 0x64, at S+2 after the third stop sample.
- Then send 0x40, 0x7F (running status): one strobe with CMD = 0x90, DAT_0 = 0x40, DAT_1 = 0x7F. Then send 0xC2, 0x05: one strobe with CMD = 0xC2, DAT_0 = 0x05, DAT_1 = 0x00.
- Send 0x80, 0xF8, 0x3C, 0xFE, 0x00: a single strobe with 0x80 / 0x3C / 0x00. The realtime bytes cause no strobe and no state change.
- Send 0x90, then 0x3C with its stop bit forced low, then line high, then 0x3C, 0x64:
  - `rx_frame_err` pulses once and no strobe occurs for the bad byte.
  - Then one strobe with 0x90 / 0x3C / 0x64.
- Send 0xF0, 0x01, 0x02, 0xF7, 0x40, 0x10: no strobe. Then send 0xB0, 0x07, 0x7F: strobe with 0xB0 / 0x07 / 0x7F.
- Robustness cases:
  - A 5-cycle low glitch on the line: no byte and no error.
  - `sys_rst` pulsed during DATA of 0x3C following 0x90: outputs are 0 and no strobe. A subsequent lone 0x3C, 0x64 produces no strobe because running status was cleared.
